scan_chain_ctrl: RTL

//   Sequences a serial scan chain of level-sensitive latches (transparent while their clock is high).

---
 rtl/scan_chain_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a parallel word LSB-first through a latch chain using two
// non-overlapping latch clocks, strobes the shadow update, and captures the serial return.
module scan_chain_ctrl #(
    parameter int WIDTH         = 8,
    parameter int PHASE_CYCLES  = 2,
    parameter int UPDATE_CYCLES = 2
) (
    input  logic             io_clk,
    input  logic             io_reset_n,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_data,
    output logic             io_scan_out,
    output logic             io_scan_clk_a,
    output logic             io_scan_clk_b,
    input  logic             io_scan_in,
    output logic             io_update,
    output logic             io_rd_valid,
    output logic [WIDTH-1:0] io_rd_data
);

    localparam int MAXC = (PHASE_CYCLES > UPDATE_CYCLES) ? PHASE_CYCLES : UPDATE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, PH_A, MID, PH_B, SETTLE, UPDATE, DONE
    } state_t;

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] rd_sreg;
    logic             ph_last, upd_last, bit_last, accept, shift;

    assign io_in_ready = (state == IDLE);
    assign io_scan_out = sreg[0];

    always_comb begin
        ph_last  = (cnt == CW'(PHASE_CYCLES - 1));
        upd_last = (cnt == CW'(UPDATE_CYCLES - 1));
        bit_last = (bit_cnt == BW'(WIDTH - 1));
        accept   = (state == IDLE) && io_in_valid;
        shift    = (state == PH_B) && ph_last;
        nxt      = state;
        case (state)
            IDLE:    if (io_in_valid) nxt = SETUP;
            SETUP:   nxt = PH_A;
            PH_A:    if (ph_last) nxt = MID;
            MID:     nxt = PH_B;
            PH_B:    if (ph_last) nxt = bit_last ? SETTLE : SETUP;
            SETTLE:  nxt = UPDATE;
            UPDATE:  if (upd_last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode so each output is a clean flop.
    always_ff @(posedge io_clk or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            sreg          <= '0;
            rd_sreg       <= '0;
            io_scan_clk_a <= 1'b0;
            io_scan_clk_b <= 1'b0;
            io_update     <= 1'b0;
            io_rd_valid   <= 1'b0;
            io_rd_data    <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + CW'(1);
            if (accept) begin
                sreg    <= io_in_data;
                rd_sreg <= '0;
                bit_cnt <= '0;
            end else if (shift) begin
                sreg    <= sreg >> 1;
                rd_sreg <= (rd_sreg >> 1) | (WIDTH'(io_scan_in) << (WIDTH - 1));
                bit_cnt <= bit_cnt + BW'(1);
            end
            io_scan_clk_a <= (nxt == PH_A);
            io_scan_clk_b <= (nxt == PH_B);
            io_update     <= (nxt == UPDATE);
            io_rd_valid   <= (nxt == DONE);
            if (nxt == DONE) io_rd_data <= rd_sreg;
        end
    end

endmodule
